// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns single-beat valid/ready commands into APB SETUP/ACCESS transfers
//   and returns each result on a valid/ready response port.
// Latency: accept -> SETUP -> ACCESS (+1 cycle per pready-low cycle) -> RESP; at most 1 transfer per 4 cycles.
// Backpressure: cmd_ready only in IDLE (no buffering); RESP holds its payload until rsp_ready.
//
// Ports:
//   pclk, preset_n                       clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_write,      command port (one outstanding command)
//   cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready, rsp_rdata,      response port; rsp_err = pslverr or timeout
//   rsp_err, rsp_timeout
//   err_cnt                              saturating count of error responses
//   busy                                 FSM not in IDLE
//   psel, penable, pwrite, paddr, pwdata APB request side
//   prdata, pready, pslverr              APB completion side
module apb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [7:0]            err_cnt,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // Wait counter only needs to reach TIMEOUT-1; keep at least one bit when the timeout is off.
  localparam int WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST_INT = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAST_INT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    timeout_q;
  logic [7:0]              err_cnt_q;
  logic [WAIT_W-1:0]       wait_cnt_q;

  logic                    timeout_hit;
  logic [7:0]              err_cnt_d;

  // Last permitted ACCESS cycle without pready; never true when the timeout is disabled.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

  // Value err_cnt takes when an error response is recorded (saturates at 255).
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            write_q    <= cmd_write;
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_wdata;
            wait_cnt_q <= '0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            err_q     <= pslverr;
            timeout_q <= 1'b0;
            // Read data is kept even on pslverr so software can inspect it.
            rdata_q   <= write_q ? '0 : prdata;
            if (pslverr) begin
              err_cnt_q <= err_cnt_d;
            end
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
            err_cnt_q <= err_cnt_d;
            state_q   <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // All handshake/APB controls decode the state register only, so reset drops them immediately.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign rsp_valid   = (state_q == ST_RESP);

  assign pwrite      = write_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;

  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = timeout_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with a behavioural slave and reference model.
// Latency: n/a (bench).
// Backpressure: rsp_ready driven always-high, random or held low depending on the phase.
module tb_apb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [7:0]    err_cnt;
  logic          busy, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  always #5 pclk = ~pclk;

  apb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_cnt(err_cnt), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    logic [7:0]    cnt;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;

  // Reference model: the response follows from how long the slave stalls and what it answers.
  function automatic exp_t model(input bit wr, input int waits, input bit serr, input logic [DW-1:0] rd);
    exp_t e;
    if (TO != 0 && waits >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.acc = TO;
    end else begin
      e.rdata = wr ? '0 : rd; e.err = serr; e.tmo = 1'b0; e.acc = waits + 1;
    end
    if (e.err && model_cnt < 255) model_cnt++;
    e.cnt = 8'(model_cnt);
    return e;
  endfunction

  // Behaviour planned for the slave on the current transfer.
  bit            plan_wr;
  logic [AW-1:0] plan_addr;
  logic [DW-1:0] plan_wdata, plan_rdata;
  bit            plan_err;
  int            plan_waits;

  int      acc = 0, last_acc = 0;
  int      rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
  longint  cyc = 0, hs_edge = 0, acc_edge = 0;

  always @(posedge pclk) cyc++;

  // Slave: answers on ACCESS cycle number plan_waits; noise on pready/prdata/pslverr elsewhere.
  always @(posedge pclk) begin
    #1;
    if (!preset_n) begin
      acc = 0;
      pready = 1'b0;
    end else if (psel && penable) begin
      chk("access_paddr", paddr, plan_addr);
      chk("access_pwrite", pwrite, plan_wr);
      chk("access_pwdata", pwdata, plan_wdata);
      if (acc == plan_waits) begin
        pready = 1'b1; prdata = plan_rdata; pslverr = plan_err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      acc++;
    end else begin
      if (acc != 0) last_acc = acc;
      acc = 0;
      pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    end
    rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom) : 1'b0;
  end

  // Monitor: pops the scoreboard on every response handshake, checks hold while stalled.
  logic          hold_pend = 1'b0;
  logic [DW-1:0] h_rdata;
  logic          h_err, h_tmo;
  exp_t          me;

  always @(negedge pclk) begin
    if (!preset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && rsp_valid) begin
        chk("hold_rdata", rsp_rdata, h_rdata);
        chk("hold_err", rsp_err, h_err);
        chk("hold_tmo", rsp_timeout, h_tmo);
      end
      hold_pend = 1'b0;
      if (rsp_valid) begin
        chk("resp_psel_penable_cmdrdy", {psel, penable, cmd_ready}, 3'b000);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=response expected=none t=%0t", $time);
          end else begin
            me = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, me.rdata);
            chk("rsp_err", rsp_err, me.err);
            chk("rsp_timeout", rsp_timeout, me.tmo);
            chk("err_cnt", err_cnt, me.cnt);
            chk("access_cycles", last_acc, me.acc);
          end
          hs_edge = cyc + 1;
        end else begin
          hold_pend = 1'b1;
          h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout;
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int waits, input bit serr, input logic [DW-1:0] rd);
    int n;
    n = 0;
    @(negedge pclk);
    while (psel && n < 300) begin @(negedge pclk); n++; end
    plan_wr = wr; plan_addr = a; plan_wdata = wd; plan_rdata = rd;
    plan_err = serr; plan_waits = waits;
    exp_q.push_back(model(wr, waits, serr, rd));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge pclk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted t=%0t", $time);
      cmd_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin @(negedge pclk); n++; end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    plan_waits = 0; plan_wr = 1'b0; plan_addr = '0; plan_wdata = '0; plan_rdata = '0; plan_err = 1'b0;
    #1;
    chk("rst_psel_penable_pwrite", {psel, penable, pwrite}, 3'b000);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy_cmdrdy", {busy, cmd_ready}, 2'b01);
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;

    // Zero-wait write: SETUP in cycle 1, ACCESS in cycle 2, response in cycle 3.
    rdy_mode = 0;
    issue(1'b1, 8'h04, 32'h0000_FFFF, 0, 1'b0, 32'h1234_5678);
    @(negedge pclk);
    chk("zw_setup", {psel, penable, pwrite}, 3'b101);
    @(negedge pclk);
    chk("zw_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    chk("zw_resp_valid", rsp_valid, 1'b1);
    drain();

    // Read with three wait states.
    issue(1'b0, 8'h00, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_A5A5);
    drain();

    // Slave error on a write.
    issue(1'b1, 8'h20, 32'h0BAD_F00D, 0, 1'b1, 32'h0);
    drain();

    // Longest normal completion, then a full timeout.
    issue(1'b0, 8'h30, 32'h1, TO - 1, 1'b0, 32'hCAFE_0001);
    issue(1'b0, 8'h34, 32'h2, 40, 1'b0, 32'hCAFE_0002);
    drain();
    repeat (4) @(negedge pclk);
    chk("post_timeout_idle", {busy, psel}, 2'b00);

    // Stalled response with a second command waiting.
    rdy_mode = 2;
    issue(1'b0, 8'h40, 32'h5, 0, 1'b0, 32'h7777_0000);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge pclk); n++; end
    fork
      issue(1'b1, 8'h44, 32'h6, 1, 1'b0, 32'h0);
      begin
        repeat (5) begin
          chk("stall_rsp_valid", rsp_valid, 1'b1);
          chk("stall_cmd_ready", cmd_ready, 1'b0);
          @(negedge pclk);
        end
        rdy_mode = 0;
      end
    join
    chk("accept_after_handshake", acc_edge, hs_edge + 1);
    drain();

    // Randomized traffic around the timeout boundary.
    rdy_mode = 1;
    repeat (150) begin
      int w;
      w = ($urandom % 8 == 0) ? 14 + int'($urandom % 6) : int'($urandom % 4);
      issue(1'($urandom), AW'($urandom), $urandom, w, ($urandom % 4) == 0, $urandom);
    end
    drain();

    // Error counter saturation.
    rdy_mode = 0;
    repeat (260) issue(1'b1, AW'($urandom), $urandom, 0, 1'b1, 32'h0);
    drain();
    chk("err_cnt_saturated", err_cnt, 8'd255);

    // Reset in the middle of ACCESS.
    issue(1'b0, 8'h10, 32'h9, 8, 1'b0, 32'h5555_AAAA);
    n = 0;
    while (!(psel && penable) && n < 50) begin @(negedge pclk); n++; end
    chk("pre_reset_in_access", {psel, penable}, 2'b11);
    preset_n = 1'b0;
    #1;
    chk("mid_reset_psel_penable_valid", {psel, penable, rsp_valid}, 3'b000);
    exp_q.delete();
    model_cnt = 0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    #1;
    chk("post_reset_cmdrdy_busy", {cmd_ready, busy}, 2'b10);
    chk("post_reset_err_cnt", err_cnt, 0);

    // Normal operation resumes after reset.
    issue(1'b0, 8'h18, 32'h3, 2, 1'b1, 32'h0F0F_0F0F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
